mbus_busy_clr_gen: RTL and testbench

MBUS_BUSY_CLR_GEN -- requirements
Module: mbus_busy_clr_gen

---
 rtl/mbus_busy_clr_gen.sv | 183 ++++++++++++++++++
 tb/tb_mbus_busy_clr_gen.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mbus_busy_clr_gen.sv
// ============================================================================
//  Module      : mbus_busy_clr_gen
//  Description : Generates the MBUS_CLR_BUSY request towards the always-on
//                busy controller. Tracks a bus transaction (IDLE -> BUSY),
//                issues a registered clear pulse of CLR_WIDTH cycles on end
//                of message (CLEAR), holds one quiet cycle (RELEASE) and
//                returns to IDLE. An optional watchdog forces the clear when
//                a transaction never completes.
//  Macros      : MBUS_BUSY_WATCHDOG_EN - build the watchdog counter and the
//                                        sticky WDT_EXPIRED flag.
//                IO_HOLD               - isolation level of BC_RELEASE_ISO
//                                        (defaults to 1'b1).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef IO_HOLD
`define IO_HOLD 1'b1
`endif

module mbus_busy_clr_gen #(
    parameter int CLR_WIDTH  = 2,     // 1..15
    parameter int WDT_CYCLES = 1023   // 1..65535
) (
    input  logic CLKIN,
    input  logic RESETn,
    input  logic BUS_BUSYn,
    input  logic BC_RELEASE_ISO,
    input  logic MSG_DONE,
    input  logic WDT_CLR,
    output logic MBUS_CLR_BUSY,
    output logic CLR_ACTIVE,
    output logic WDT_EXPIRED
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY    = 2'd1,
        ST_CLEAR   = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    // Last value of the clear-width counter before leaving CLEAR.
    localparam logic [3:0] C_CLR_LAST = 4'(CLR_WIDTH - 1);

    state_t     state_q, state_d;
    logic [3:0] clr_cnt_q, clr_cnt_d;
    logic       clr_busy_q, clr_busy_d;
    logic       iso_hold;
    logic       wdt_fire;

    // While isolated the request must never reach the busy controller.
    assign iso_hold = (BC_RELEASE_ISO == `IO_HOLD);

`ifdef MBUS_BUSY_WATCHDOG_EN
    localparam logic [15:0] C_WDT_LAST = 16'(WDT_CYCLES - 1);

    logic [15:0] wdt_cnt_q, wdt_cnt_d;
    logic        wdt_exp_q, wdt_exp_d;
    logic        wdt_set;

    // Watchdog reaches its limit on the WDT_CYCLES-th cycle spent in BUSY.
    assign wdt_fire    = (wdt_cnt_q == C_WDT_LAST);
    assign WDT_EXPIRED = wdt_exp_q;
`else
    logic unused_wdt;

    assign wdt_fire    = 1'b0;
    assign WDT_EXPIRED = 1'b0;
    assign unused_wdt  = ^{WDT_CLR, 16'(WDT_CYCLES)};
`endif

    // State, clear-width counter and registered clear request.
    always_ff @(posedge CLKIN or negedge RESETn) begin
        if (!RESETn) begin
            state_q    <= ST_IDLE;
            clr_cnt_q  <= 4'd0;
            clr_busy_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            clr_busy_q <= clr_busy_d;
        end
    end

`ifdef MBUS_BUSY_WATCHDOG_EN
    // Watchdog counter and sticky expiry flag.
    always_ff @(posedge CLKIN or negedge RESETn) begin
        if (!RESETn) begin
            wdt_cnt_q <= 16'd0;
            wdt_exp_q <= 1'b0;
        end else begin
            wdt_cnt_q <= wdt_cnt_d;
            wdt_exp_q <= wdt_exp_d;
        end
    end
`endif

    // Next-state logic; isolation overrides every state and flushes counters.
    always_comb begin
        state_d    = state_q;
        clr_cnt_d  = clr_cnt_q;
        clr_busy_d = clr_busy_q;
`ifdef MBUS_BUSY_WATCHDOG_EN
        wdt_cnt_d  = wdt_cnt_q;
        wdt_set    = 1'b0;
`endif
        if (iso_hold) begin
            state_d    = ST_IDLE;
            clr_cnt_d  = 4'd0;
            clr_busy_d = 1'b0;
`ifdef MBUS_BUSY_WATCHDOG_EN
            wdt_cnt_d  = 16'd0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!BUS_BUSYn) begin
                        state_d = ST_BUSY;
`ifdef MBUS_BUSY_WATCHDOG_EN
                        wdt_cnt_d = 16'd0;
`endif
                    end
                end
                ST_BUSY: begin
                    // MSG_DONE wins over a simultaneous watchdog expiry.
                    if (MSG_DONE) begin
                        state_d    = ST_CLEAR;
                        clr_cnt_d  = 4'd0;
                        clr_busy_d = 1'b1;
                    end else if (wdt_fire) begin
                        state_d    = ST_CLEAR;
                        clr_cnt_d  = 4'd0;
                        clr_busy_d = 1'b1;
`ifdef MBUS_BUSY_WATCHDOG_EN
                        wdt_set    = 1'b1;
`endif
                    end else if (BUS_BUSYn) begin
                        state_d = ST_IDLE;
                    end else begin
`ifdef MBUS_BUSY_WATCHDOG_EN
                        if (wdt_cnt_q != 16'hFFFF) begin
                            wdt_cnt_d = wdt_cnt_q + 16'd1;
                        end
`endif
                    end
                end
                ST_CLEAR: begin
                    if (clr_cnt_q == C_CLR_LAST) begin
                        state_d    = ST_RELEASE;
                        clr_cnt_d  = 4'd0;
                        clr_busy_d = 1'b0;
                    end else begin
                        clr_cnt_d = clr_cnt_q + 4'd1;
                    end
                end
                ST_RELEASE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
`ifdef MBUS_BUSY_WATCHDOG_EN
        // A new expiry takes precedence over a clear in the same cycle.
        if (wdt_set) begin
            wdt_exp_d = 1'b1;
        end else if (WDT_CLR) begin
            wdt_exp_d = 1'b0;
        end else begin
            wdt_exp_d = wdt_exp_q;
        end
`endif
    end

    // Registered request, gated combinationally by isolation.
    assign MBUS_CLR_BUSY = clr_busy_q & ~iso_hold;
    assign CLR_ACTIVE    = (state_q == ST_CLEAR);

endmodule

`default_nettype wire

// File: tb/tb_mbus_busy_clr_gen.sv
// ============================================================================
//  Module      : tb_mbus_busy_clr_gen
//  Description : Self-checking bench for mbus_busy_clr_gen. Two instances
//                (clear width 2 and 4) share the stimulus; a transaction-level
//                model predicts every output on every cycle, and directed
//                literal checks pin the model at key points.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef IO_HOLD
`define IO_HOLD 1'b1
`endif

module tb_mbus_busy_clr_gen;

    localparam int   TB_WDT   = 8;
    localparam logic ISO_HOLD = `IO_HOLD;
    localparam logic ISO_RUN  = ~ISO_HOLD;

    logic clk        = 1'b0;
    logic rst_n      = 1'b0;
    logic bus_busy_n = 1'b1;
    logic iso        = ISO_RUN;
    logic msg_done   = 1'b0;
    logic wdt_clr    = 1'b0;

    logic clr2, act2, wdt2;
    logic clr4, act4, wdt4;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mbus_busy_clr_gen #(.CLR_WIDTH(2), .WDT_CYCLES(TB_WDT)) u_dut2 (
        .CLKIN          (clk),
        .RESETn         (rst_n),
        .BUS_BUSYn      (bus_busy_n),
        .BC_RELEASE_ISO (iso),
        .MSG_DONE       (msg_done),
        .WDT_CLR        (wdt_clr),
        .MBUS_CLR_BUSY  (clr2),
        .CLR_ACTIVE     (act2),
        .WDT_EXPIRED    (wdt2)
    );

    mbus_busy_clr_gen #(.CLR_WIDTH(4), .WDT_CYCLES(TB_WDT)) u_dut4 (
        .CLKIN          (clk),
        .RESETn         (rst_n),
        .BUS_BUSYn      (bus_busy_n),
        .BC_RELEASE_ISO (iso),
        .MSG_DONE       (msg_done),
        .WDT_CLR        (wdt_clr),
        .MBUS_CLR_BUSY  (clr4),
        .CLR_ACTIVE     (act4),
        .WDT_EXPIRED    (wdt4)
    );

    // Transaction view: are we inside a bus transaction and for how many
    // cycles, how many clear cycles remain, is this the quiet cycle, flag.
    typedef struct packed {
        logic        in_busy;
        int unsigned nbusy;
        int unsigned clr_left;
        logic        rel;
        logic        wdt;
    } mdl_t;

    localparam mdl_t M_RST = '{in_busy: 1'b0, nbusy: 0, clr_left: 0,
                               rel: 1'b0, wdt: 1'b0};

    mdl_t m2 = M_RST;
    mdl_t m4 = M_RST;

    function automatic mdl_t step(input mdl_t s, input int unsigned cw);
        mdl_t n;
        logic set;
        n   = s;
        set = 1'b0;
        if (iso == ISO_HOLD) begin
            n.in_busy  = 1'b0;
            n.clr_left = 0;
            n.rel      = 1'b0;
        end else if (s.clr_left > 0) begin
            n.clr_left = s.clr_left - 1;
            n.rel      = (s.clr_left == 1);
        end else if (s.rel) begin
            n.rel = 1'b0;
        end else if (s.in_busy) begin
            if (msg_done) begin
                n.in_busy  = 1'b0;
                n.clr_left = cw;
            end
`ifdef MBUS_BUSY_WATCHDOG_EN
            else if (s.nbusy == TB_WDT) begin
                n.in_busy  = 1'b0;
                n.clr_left = cw;
                set        = 1'b1;
            end
`endif
            else if (bus_busy_n) begin
                n.in_busy = 1'b0;
            end else begin
                n.nbusy = s.nbusy + 1;
            end
        end else if (!bus_busy_n) begin
            n.in_busy = 1'b1;
            n.nbusy   = 1;
        end
        if (set)          n.wdt = 1'b1;
        else if (wdt_clr) n.wdt = 1'b0;
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m2 <= M_RST;
            m4 <= M_RST;
        end else begin
            m2 <= step(m2, 2);
            m4 <= step(m4, 4);
        end
    end

    task automatic chk(input string name, input logic got, input logic exp);
        checks = checks + 1;
        if (got !== exp) begin
            failures = failures + 1;
            $display("FAIL %s at t=%0t: got %b, expected %b", name, $time, got, exp);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("model clr2", clr2, (m2.clr_left > 0) && (iso != ISO_HOLD));
        chk("model act2", act2, (m2.clr_left > 0));
        chk("model wdt2", wdt2, m2.wdt);
        chk("model clr4", clr4, (m4.clr_left > 0) && (iso != ISO_HOLD));
        chk("model act4", act4, (m4.clr_left > 0));
        chk("model wdt4", wdt4, m4.wdt);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        repeat (3) tick();
        chk("reset clr2", clr2, 1'b0);
        chk("reset act4", act4, 1'b0);
        chk("reset wdt2", wdt2, 1'b0);
        rst_n = 1'b1;
        repeat (2) tick();
        chk("idle after reset", act2, 1'b0);

        // Normal clear: MSG_DONE five cycles after busy
        bus_busy_n = 1'b0;
        repeat (5) tick();
        chk("busy no clear", clr2, 1'b0);
        msg_done = 1'b1;
        tick();
        msg_done   = 1'b0;
        bus_busy_n = 1'b1;
        chk("sc1 clr cyc1", clr2, 1'b1);
        chk("sc1 act cyc1", act2, 1'b1);
        tick();
        chk("sc1 clr cyc2", clr2, 1'b1);
        tick();
        chk("sc1 release clr2", clr2, 1'b0);
        chk("sc1 release act2", act2, 1'b0);
        chk("sc1 w4 still clr", clr4, 1'b1);
        repeat (4) tick();
        chk("sc1 w4 done", act4, 1'b0);

        // Bus released without message: back to idle, no clear
        bus_busy_n = 1'b0;
        repeat (3) tick();
        bus_busy_n = 1'b1;
        repeat (2) tick();
        chk("abort no clear", clr2, 1'b0);

`ifdef MBUS_BUSY_WATCHDOG_EN
        // Watchdog expiry, with WDT_CLR colliding with the set
        bus_busy_n = 1'b0;
        repeat (8) tick();
        chk("wdt pre act", act2, 1'b0);
        wdt_clr = 1'b1;
        tick();
        wdt_clr    = 1'b0;
        bus_busy_n = 1'b1;
        chk("wdt clear entered", act2, 1'b1);
        chk("wdt set wins", wdt2, 1'b1);
        repeat (6) tick();
        chk("wdt sticky", wdt2, 1'b1);
        wdt_clr = 1'b1;
        tick();
        wdt_clr = 1'b0;
        chk("wdt cleared", wdt2, 1'b0);

        // MSG_DONE on the 8th busy cycle: no expiry
        bus_busy_n = 1'b0;
        repeat (8) tick();
        msg_done = 1'b1;
        tick();
        msg_done   = 1'b0;
        bus_busy_n = 1'b1;
        chk("simul clear", act2, 1'b1);
        chk("simul no wdt", wdt2, 1'b0);
        repeat (6) tick();
`endif

        // Isolation in the first CLEAR cycle
        bus_busy_n = 1'b0;
        repeat (3) tick();
        msg_done = 1'b1;
        tick();
        msg_done = 1'b0;
        iso      = ISO_HOLD;
        #1;
        chk("iso clr forced 0", clr2, 1'b0);
        chk("iso act still", act2, 1'b1);
        tick();
        chk("iso idle", act2, 1'b0);
        iso        = ISO_RUN;
        bus_busy_n = 1'b1;
        repeat (2) tick();
        chk("iso after", clr4, 1'b0);

        // Reset mid-CLEAR (width-4 instance in its 2nd clear cycle)
        bus_busy_n = 1'b0;
        repeat (2) tick();
        msg_done = 1'b1;
        tick();
        msg_done   = 1'b0;
        bus_busy_n = 1'b1;
        chk("pre-rst clr4", clr4, 1'b1);
        tick();
        rst_n = 1'b0;
        #1;
        chk("async rst clr4", clr4, 1'b0);
        chk("async rst act4", act4, 1'b0);
        chk("async rst wdt4", wdt4, 1'b0);
        chk("async rst clr2", clr2, 1'b0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (3) tick();
        chk("post-rst idle", act4, 1'b0);
        bus_busy_n = 1'b0;
        tick();
        msg_done = 1'b1;
        tick();
        msg_done   = 1'b0;
        bus_busy_n = 1'b1;
        chk("post-rst clear", clr4, 1'b1);
        repeat (6) tick();

`ifndef MBUS_BUSY_WATCHDOG_EN
        // Long busy with watchdog absent: never cleared
        bus_busy_n = 1'b0;
        repeat (2000) tick();
        chk("long busy no clr", clr2, 1'b0);
        chk("long busy no wdt", wdt2, 1'b0);
        bus_busy_n = 1'b1;
        repeat (2) tick();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
